updown_counter_p: RTL and testbench

//   Parametrised successor to the basic free-running 16-bit counter.
//   Up/down counter with programmable modulus, synchronous load/clear,

---
 rtl/updown_counter_p_pkg.sv | 13 +
 rtl/updown_counter_p_cnt_limit_detect.sv | 32 +++
 rtl/updown_counter_p.sv | 88 ++++++++
 tb/tb_updown_counter_p.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/updown_counter_p_pkg.sv
// Shared types for the up/down counter family: the data bit type and the
// wrap/saturate mode encoding.
package counter_pkg;

`ifdef TWO_STATE
    typedef bit dtype_t;
`else
    typedef logic dtype_t;
`endif

    typedef enum dtype_t {CNT_WRAP, CNT_SAT} mode_t;

endpackage

// File: rtl/updown_counter_p_cnt_limit_detect.sv
// Combinational limit detection and single-step next value for the counter,
// evaluated in WIDTH+1 bits so the step itself can never overflow.
module cnt_limit_detect #(
    parameter int          WIDTH     = 16,
    parameter int unsigned MAX_COUNT = 2**WIDTH-1
) (
    input  logic [WIDTH-1:0] count,
    input  logic             up,
    output logic             at_max,
    output logic             at_zero,
    output logic             over_max,
    output logic [WIDTH-1:0] next_val
);

    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_COUNT);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

    logic [WIDTH:0] count_ext;
    logic [WIDTH:0] step_ext;

    assign count_ext = {1'b0, count};
    assign step_ext  = up ? (count_ext + 1'b1) : (count_ext - 1'b1);

    assign at_max   = (count_ext == MAX_EXT);
    assign at_zero  = (count == '0);
    assign over_max = (count_ext > MAX_EXT);

    // The caller only uses next_val away from the limits; the clamp keeps an
    // out-of-range step from ever producing a value above MAX_COUNT.
    assign next_val = (step_ext > MAX_EXT) ? MAX_VAL : step_ext[WIDTH-1:0];

endmodule

// File: rtl/updown_counter_p.sv
// Up/down counter with programmable terminal value, synchronous clear/load,
// count enable and run-time selectable wrap or saturate behaviour.
module updown_counter_p
    import counter_pkg::*;
#(
    parameter int          WIDTH     = 16,
    parameter int unsigned MAX_COUNT = 2**WIDTH-1,
    parameter mode_t       DEF_MODE  = CNT_WRAP
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             enable,
    input  logic             up,
    input  logic             mode_sel,
    output logic [WIDTH-1:0] count,
    output logic             at_limit,
    output logic             wrapped
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

    if (WIDTH < 2 || MAX_COUNT < 1 || MAX_COUNT > 2**WIDTH-1) begin : g_bad_param
        $error("updown_counter_p: illegal WIDTH/MAX_COUNT combination");
    end

    dtype_t [WIDTH-1:0] count_reg;
    dtype_t             wrapped_reg;
    mode_t              eff_mode;

    logic             at_max;
    logic             at_zero;
    logic             over_max;
    logic [WIDTH-1:0] next_val;

    assign eff_mode = mode_sel ? ((DEF_MODE == CNT_WRAP) ? CNT_SAT : CNT_WRAP) : DEF_MODE;

    cnt_limit_detect #(
        .WIDTH     (WIDTH),
        .MAX_COUNT (MAX_COUNT)
    ) u_limit (
        .count    (count_reg),
        .up       (up),
        .at_max   (at_max),
        .at_zero  (at_zero),
        .over_max (over_max),
        .next_val (next_val)
    );

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            count_reg   <= '0;
            wrapped_reg <= 1'b0;
        end else if (clear) begin
            count_reg   <= '0;
            wrapped_reg <= 1'b0;
        end else if (load) begin
            count_reg <= (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (enable) begin
            // An out-of-range count (only from X/illegal state) is pulled
            // back to the terminal value regardless of direction.
            if (over_max) begin
                count_reg <= MAX_VAL;
            end else if (up) begin
                if (!at_max) begin
                    count_reg <= next_val;
                end else if (eff_mode == CNT_WRAP) begin
                    count_reg   <= '0;
                    wrapped_reg <= 1'b1;
                end
            end else begin
                if (!at_zero) begin
                    count_reg <= next_val;
                end else if (eff_mode == CNT_WRAP) begin
                    count_reg   <= MAX_VAL;
                    wrapped_reg <= 1'b1;
                end
            end
        end
    end

    assign count    = count_reg;
    assign wrapped  = wrapped_reg;
    assign at_limit = enable & (up ? at_max : at_zero);

endmodule

// File: tb/tb_updown_counter_p.sv
// Scoreboard bench for updown_counter_p (WIDTH=4, MAX_COUNT=9, wrap default).
module tb_updown_counter_p;
    import counter_pkg::*;

    logic       clock;
    logic       resetN;
    logic       clear;
    logic       load;
    logic [3:0] load_val;
    logic       enable;
    logic       up;
    logic       mode_sel;
    logic [3:0] count;
    logic       at_limit;
    logic       wrapped;

    typedef struct {
        string name;
        int    cnt;
        int    wr;
        int    lim;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    updown_counter_p #(
        .WIDTH     (4),
        .MAX_COUNT (9),
        .DEF_MODE  (CNT_WRAP)
    ) dut (
        .clock    (clock),
        .resetN   (resetN),
        .clear    (clear),
        .load     (load),
        .load_val (load_val),
        .enable   (enable),
        .up       (up),
        .mode_sel (mode_sel),
        .count    (count),
        .at_limit (at_limit),
        .wrapped  (wrapped)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act == req) begin
            passes++;
            $display("ok   %s: %0d", name, act);
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: compares every queued expectation on the falling edge, while
    // the inputs that produced it are still applied.
    always @(negedge clock) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.name, ".count"},    int'(count),    e.cnt);
            check({e.name, ".wrapped"},  int'(wrapped),  e.wr);
            check({e.name, ".at_limit"}, int'(at_limit), e.lim);
        end
    end

    task automatic step(input string name, input bit cl, input bit ld, input int lv,
                        input bit en, input bit u, input bit ms,
                        input int ec, input int ew, input int el);
        exp_t e;
        clear    = cl;
        load     = ld;
        load_val = 4'(lv);
        enable   = en;
        up       = u;
        mode_sel = ms;
        @(posedge clock);
        e.name = name;
        e.cnt  = ec;
        e.wr   = ew;
        e.lim  = el;
        exp_q.push_back(e);
        @(negedge clock);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        resetN = 1'b0; clear = 0; load = 0; load_val = 0;
        enable = 0; up = 0; mode_sel = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("in_reset.count", int'(count), 0);
        resetN = 1'b1;
        #1;

        //    name          cl ld lv en up ms  cnt wr lim
        step("reset_state", 0, 0, 0, 0, 0, 0,  0, 0, 0);

        // Up wrap
        step("upw_load8",   0, 1, 8, 0, 1, 0,  8, 0, 0);
        step("upw_e1",      0, 0, 0, 1, 1, 0,  9, 0, 1);
        step("upw_e2",      0, 0, 0, 1, 1, 0,  0, 1, 0);
        step("upw_e3",      0, 0, 0, 1, 1, 0,  1, 1, 0);

        // Async reset mid-cycle with count=5, wrapped=1
        step("rst_load5",   0, 1, 5, 0, 0, 0,  5, 1, 0);
        #1;
        resetN = 1'b0;
        #1;
        check("async_rst.count",   int'(count),   0);
        check("async_rst.wrapped", int'(wrapped), 0);
        @(negedge clock);
        resetN = 1'b1;
        #1;

        // Down saturate
        step("dsat_load2",  0, 1, 2, 0, 0, 1,  2, 0, 0);
        step("dsat_e1",     0, 0, 0, 1, 0, 1,  1, 0, 0);
        step("dsat_e2",     0, 0, 0, 1, 0, 1,  0, 0, 1);
        step("dsat_e3",     0, 0, 0, 1, 0, 1,  0, 0, 1);
        step("dsat_e4",     0, 0, 0, 1, 0, 1,  0, 0, 1);

        // Direction flip in wrap mode from 0
        step("flip_up",     0, 0, 0, 1, 1, 0,  1, 0, 0);
        step("flip_dn",     0, 0, 0, 1, 0, 0,  0, 0, 1);
        step("flip_dnwrap", 0, 0, 0, 1, 0, 0,  9, 1, 0);
        step("flip_upwrap", 0, 0, 0, 1, 1, 0,  0, 1, 0);

        // Load clamp with enable high, then clear beats load
        step("clamp15",     0, 1, 15, 1, 1, 0, 9, 1, 1);
        step("clr_vs_load", 1, 1, 5, 1, 1, 0,  0, 0, 0);

        // Saturate at top, load priority over enable, hold
        step("usat_load9",  0, 1, 9, 0, 1, 1,  9, 0, 0);
        step("usat_hold",   0, 0, 0, 1, 1, 1,  9, 0, 1);
        step("ld_vs_en",    0, 1, 3, 1, 0, 0,  3, 0, 0);
        step("idle_hold",   0, 0, 0, 0, 0, 0,  3, 0, 0);
        step("dn_step",     0, 0, 0, 1, 0, 0,  2, 0, 0);

        repeat (2) @(negedge clock);
        checks++;
        if (exp_q.size() == 0) passes++;
        else $display("FAIL drain: %0d entries left, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
